// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response channel between the fetch stage
// (master) and instruction memory (slave).
//   req       master->slave  request valid
//   addr      master->slave  request address
//   gnt       slave->master  request accepted this cycle
//   rsp_valid slave->master  response data valid
//   rsp_data  slave->master  response instruction word
interface fetch_stage_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  logic                  req;
  logic [DATA_WIDTH-1:0] addr;
  logic                  gnt;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rsp_valid,
    output rsp_data
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the pipelined core. Owns the PC, issues at most one outstanding
// instruction-memory request, and presents the fetched instruction to the F->D register.
// Handles hazard-unit stalls (hold the instruction) and execute-stage redirects.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   imem            instruction-memory channel (fetch_stage_if.master)
//   StallF_i        hold the current instruction, it is not consumed
//   PCSrcE_i        redirect to PCTargetE_i (wins over StallF_i)
//   PCTargetE_i     redirect target, low two bits ignored
//   InstrF_o        fetched instruction, NOP when ValidF_o=0
//   PCF_o           PC of InstrF_o / current fetch address
//   PCPlus4F_o      PCF_o + 4 (wraps)
//   ValidF_o        InstrF_o valid
//   FetchCount_o    instructions consumed (FETCH_PERF_EN only, else 0)
//   RedirectCnt_o   redirect cycles outside BOOT (FETCH_PERF_EN only, else 0)
//
// Build option: define FETCH_PERF_EN to build the two performance counters.
module fetch_stage #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  RESET_PC   = DATA_WIDTH'(32'hBFC00000)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_stage_if.master         imem,
  input  logic                  StallF_i,
  input  logic                  PCSrcE_i,
  input  logic [DATA_WIDTH-1:0] PCTargetE_i,
  output logic [DATA_WIDTH-1:0] InstrF_o,
  output logic [DATA_WIDTH-1:0] PCF_o,
  output logic [DATA_WIDTH-1:0] PCPlus4F_o,
  output logic                  ValidF_o,
  output logic [31:0]           FetchCount_o,
  output logic [31:0]           RedirectCnt_o
);

  localparam logic [DATA_WIDTH-1:0] Nop = DATA_WIDTH'(32'h00000013);

  typedef enum logic [2:0] {StBoot, StReq, StWait, StHold, StDrain} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] instr_q;

  logic                  redirect;
  logic                  consume;
  logic                  valid;
  logic [DATA_WIDTH-1:0] instr;
  logic [DATA_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] target_aligned;
  logic                  unused_target_lsbs;

  assign pc_plus4           = pc_q + DATA_WIDTH'(4);
  assign target_aligned     = {PCTargetE_i[DATA_WIDTH-1:2], 2'b00};
  assign unused_target_lsbs = ^PCTargetE_i[1:0];

  // BOOT ignores redirects entirely: no PC update, no count.
  assign redirect = PCSrcE_i && (state_q != StBoot);

  // A redirect kills whatever instruction is on offer this cycle.
  always_comb begin
    valid = 1'b0;
    instr = Nop;
    case (state_q)
      StWait: begin
        if (imem.rsp_valid && !PCSrcE_i) begin
          valid = 1'b1;
          instr = imem.rsp_data;
        end
      end
      StHold: begin
        if (!PCSrcE_i) begin
          valid = 1'b1;
          instr = instr_q;
        end
      end
      default: ;
    endcase
  end

  assign consume = valid && !StallF_i;

  assign imem.req  = (state_q == StReq) && !PCSrcE_i;
  assign imem.addr = pc_q;

  assign InstrF_o   = instr;
  assign ValidF_o   = valid;
  assign PCF_o      = pc_q;
  assign PCPlus4F_o = pc_plus4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      instr_q <= Nop;
    end else begin
      if (redirect) begin
        pc_q <= target_aligned;
      end else if (consume) begin
        pc_q <= pc_plus4;
      end

      case (state_q)
        StBoot: state_q <= StReq;
        StReq: begin
          if (!PCSrcE_i && imem.gnt) state_q <= StWait;
        end
        StWait: begin
          if (PCSrcE_i) begin
            // Without the response in hand it is still in flight and must be drained.
            state_q <= imem.rsp_valid ? StReq : StDrain;
          end else if (imem.rsp_valid) begin
            if (StallF_i) begin
              instr_q <= imem.rsp_data;
              state_q <= StHold;
            end else begin
              state_q <= StReq;
            end
          end
        end
        StHold: begin
          if (PCSrcE_i || !StallF_i) state_q <= StReq;
        end
        StDrain: begin
          if (imem.rsp_valid) state_q <= StReq;
        end
        default: state_q <= StBoot;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] redirect_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (consume)  fetch_cnt_q    <= fetch_cnt_q + 32'd1;
      if (redirect) redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign FetchCount_o  = fetch_cnt_q;
  assign RedirectCnt_o = redirect_cnt_q;
`else
  assign FetchCount_o  = '0;
  assign RedirectCnt_o = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized bench for fetch_stage. A memory model answers granted requests
// with random latency (word = hash of address); a monitor compares the DUT against an
// architectural model (expected PC queue, "instruction on offer" flag) every cycle.
module tb_fetch_stage;

  localparam int unsigned DW      = 32;
  localparam logic [31:0] ResetPc = 32'hBFC00000;
  localparam logic [31:0] Nop     = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall;
  logic        pcsrc;
  logic [31:0] target;
  logic [31:0] instr_f, pc_f, pc_plus4_f, fetch_count, redirect_cnt;
  logic        valid_f;

  fetch_stage_if #(.DATA_WIDTH(DW)) imem ();

  fetch_stage #(
    .DATA_WIDTH (DW),
    .RESET_PC   (ResetPc)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (imem),
    .StallF_i      (stall),
    .PCSrcE_i      (pcsrc),
    .PCTargetE_i   (target),
    .InstrF_o      (instr_f),
    .PCF_o         (pc_f),
    .PCPlus4F_o    (pc_plus4_f),
    .ValidF_o      (valid_f),
    .FetchCount_o  (fetch_count),
    .RedirectCnt_o (redirect_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  exp_t        exp_q[$];
  bit          mon_en = 1'b0;
  bit          directed = 1'b0;
  bit          held = 1'b0;
  bit          fresh = 1'b0;
  bit          acc = 1'b0;
  logic [31:0] acc_addr = '0;
  bit          pending = 1'b0;
  bit          pend_stale = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          cyc = 0;
  int          since_reset = 0;
  int          last_valid_cyc = -1;
  int          last_deliv = 0;
  int          model_fetches = 0;
  int          model_redirects = 0;
  bit          reset_done = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00500093;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] p);
    exp_t e;
    e.pc    = p;
    e.instr = mem_word(p);
    exp_q.push_back(e);
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(3))
      0:       t = 32'hBFC00103;
      1:       t = 32'hBFC00040;
      2:       t = 32'hFFFFFFF0 | 32'($urandom_range(15));
      default: t = $urandom;
    endcase
    return t;
  endfunction

  // Asynchronous reset at an arbitrary point; outputs must take reset values at once.
  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("rst_valid", valid_f, 0);
    check("rst_req", imem.req, 0);
    check("rst_instr", instr_f, Nop);
    check("rst_pc", pc_f, ResetPc);
    check("rst_pc_plus4", pc_plus4_f, ResetPc + 32'd4);
    check("rst_fetch_count", fetch_count, 0);
    check("rst_redirect_cnt", redirect_cnt, 0);
    stall          = 1'b0;
    pcsrc          = 1'b0;
    target         = '0;
    imem.gnt       = 1'b0;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = '0;
    pending        = 1'b0;
    pend_stale     = 1'b0;
    fresh          = 1'b0;
    model_redirects = 0;
    repeat (2) @(negedge clk);
    rst_n       = 1'b1;
    since_reset = 0;
    mon_en      = 1'b1;
  endtask

  // One cycle of stimulus plus the memory model, driven just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    since_reset++;
    if (acc) begin
      pending    = 1'b1;
      pend_stale = 1'b0;
      pend_addr  = acc_addr;
      pend_cnt   = directed ? 0 : int'($urandom_range(3));
    end
    fresh          = 1'b0;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = $urandom;
    if (pending) begin
      if (pend_cnt == 0) begin
        imem.rsp_valid = 1'b1;
        imem.rsp_data  = mem_word(pend_addr);
        fresh          = !pend_stale;
        pending        = 1'b0;
      end else begin
        pend_cnt--;
      end
    end else if (!directed && $urandom_range(9) == 0) begin
      imem.rsp_valid = 1'b1;  // unsolicited response, must be ignored
    end
    stall = directed ? 1'b0 : ($urandom_range(99) < 35);
    pcsrc = 1'b0;
    if (!directed && since_reset >= 2 && $urandom_range(99) < 10) begin
      pcsrc  = 1'b1;
      target = pick_target();
      model_redirects++;
      if (pending) pend_stale = 1'b1;
    end
    imem.gnt = directed ? 1'b1 : ($urandom_range(99) < 70);
  endtask

  // Monitor: architectural model of what the stage must present this cycle.
  always @(negedge clk) begin : monitor
    logic        exp_valid;
    logic [31:0] exp_pc;
    acc      = rst_n && imem.req && imem.gnt;
    acc_addr = imem.addr;
    if (!mon_en) begin
      held           = 1'b0;
      model_fetches  = 0;
      last_valid_cyc = -1;
      last_deliv     = cyc;
      exp_q.delete();
      push_exp(ResetPc);
    end else begin
      exp_pc    = exp_q[0].pc;
      exp_valid = (fresh || held) && !pcsrc;
      check("valid_f", valid_f, exp_valid);
      check("pc_f", pc_f, exp_pc);
      check("pc_plus4_f", pc_plus4_f, exp_pc + 32'd4);
      if (valid_f) check("instr_f", instr_f, exp_q[0].instr);
      else         check("nop_when_invalid", instr_f, Nop);
      if (imem.req) begin
        check("imem_addr", imem.addr, exp_pc);
        check("no_req_while_valid", valid_f, 0);
      end
      if (acc) check("single_outstanding", pending, 0);
      if (exp_valid && directed) begin
        if (last_valid_cyc >= 0) check("pulse_spacing", cyc - last_valid_cyc, 2);
        last_valid_cyc = cyc;
      end
      if (exp_valid) begin
        last_deliv = cyc;
      end else if (cyc - last_deliv > 100) begin
        check("delivery_timeout", cyc - last_deliv, 100);
        last_deliv = cyc;
      end
      if (pcsrc) begin
        exp_q.delete();
        push_exp({target[31:2], 2'b00});
      end else if (exp_valid && !stall) begin
        model_fetches++;
        exp_q.delete();
        push_exp(exp_pc + 32'd4);
      end
      held = exp_valid && stall;
    end
  end

  initial begin
    stall          = 1'b0;
    pcsrc          = 1'b0;
    target         = '0;
    imem.gnt       = 1'b0;
    imem.rsp_valid = 1'b0;
    imem.rsp_data  = '0;
    #2;
    do_reset();

    // 1-cycle memory, no stalls: back-to-back sequential fetch from RESET_PC.
    directed = 1'b1;
    repeat (30) step();

    directed = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      step();
      if (!reset_done && i >= 400 && pending && !pend_stale && pend_cnt > 0) begin
        #2;
        do_reset();
        reset_done = 1'b1;
      end
    end

    @(posedge clk);
    #1;
`ifdef FETCH_PERF_EN
    check("fetch_count", fetch_count, model_fetches);
    check("redirect_cnt", redirect_cnt, model_redirects);
`else
    check("fetch_count_off", fetch_count, 0);
    check("redirect_cnt_off", redirect_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
